// File: rtl/mem_controller_if.sv
// Request/response and RAM-bus signal bundle for mem_controller.
// The slave modport is the controller; master is the requester/RAM side.
interface mem_controller_if;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        if_request;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        lsb_request;
  logic        lsb_sign;
  logic [1:0]  lsb_type;
  logic [31:0] lsb_addr;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic        st_request;
  logic [1:0]  st_type;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_done;

  modport slave (
    input  mem_din, io_buffer_full, if_request, if_addr, lsb_request, lsb_sign,
           lsb_type, lsb_addr, st_request, st_type, st_addr, st_data,
    output mem_dout, mem_a, mem_wr, if_valid, if_inst, mem_valid, mem_data, st_done
  );

  modport master (
    output mem_din, io_buffer_full, if_request, if_addr, lsb_request, lsb_sign,
           lsb_type, lsb_addr, st_request, st_type, st_addr, st_data,
    input  mem_dout, mem_a, mem_wr, if_valid, if_inst, mem_valid, mem_data, st_done
  );
endinterface

// File: rtl/mem_controller.sv
// mem_controller: arbitrates fetch, load and store requests and serialises
// each access onto an 8-bit little-endian RAM bus, one byte per cycle.
// Optional feature: define MEMCTRL_IO_STALL_EN to stall store bytes aimed
// at the IO region (address >= IO_BASE) while io_buffer_full is high.
module mem_controller #(
  parameter logic [31:0] IO_BASE = 32'h00030000
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            clear,
  mem_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state, state_nxt;

  logic        if_pend, ld_pend, st_pend;
  logic [31:0] if_addr_q, ld_addr_q, st_addr_q, st_data_q;
  logic [1:0]  ld_type_q, st_type_q;
  logic        ld_sign_q;

  logic [31:0] act_addr, act_data, shreg;
  logic [2:0]  act_n, cnt;
  logic        act_sign, act_fetch;

  logic        if_av, ld_av, st_av;
  logic        grant_if, grant_ld, grant_st;
  logic        rd_last, wr_step, stall;
  logic [31:0] wr_word, rd_word;

  // Bytes moved for a given access type: byte, half, word.
  function automatic logic [2:0] width_of(input logic [1:0] t);
    logic [2:0] n;
    case (t)
      2'd0:    n = 3'd1;
      2'd1:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Bytes arrive at the top of the shift register, so a narrow access sits
  // left-aligned; move it down and sign- or zero-fill.
  function automatic logic [31:0] extend(input logic [31:0] sh, input logic [2:0] n,
                                         input logic sgn);
    logic [31:0] r;
    case (n)
      3'd1:    r = {{24{sgn & sh[31]}}, sh[31:24]};
      3'd2:    r = {{16{sgn & sh[31]}}, sh[31:16]};
      default: r = sh;
    endcase
    return r;
  endfunction

  // A port competes if its slot is pending or it requests this cycle;
  // clear removes fetch/load from contention, stores survive it.
  assign st_av   = st_pend | bus.st_request;
  assign ld_av   = ~clear & (ld_pend | bus.lsb_request);
  assign if_av   = ~clear & (if_pend | bus.if_request);
  assign wr_word = act_data >> {cnt, 3'b000};
  assign rd_word = {bus.mem_din, shreg[31:8]};

`ifdef MEMCTRL_IO_STALL_EN
  assign stall = bus.io_buffer_full & (act_addr >= IO_BASE);
`else
  logic unused_io;
  assign unused_io = bus.io_buffer_full | (IO_BASE == 32'd0);
  assign stall     = 1'b0;
`endif

  // State register; rdy_in low freezes it.
  always_ff @(posedge clk_in) begin
    if (rst_in)      state <= IDLE;
    else if (rdy_in) state <= state_nxt;
  end

  // Next state, arbitration grants and RAM bus drive.
  always_comb begin
    state_nxt    = state;
    grant_st     = 1'b0;
    grant_ld     = 1'b0;
    grant_if     = 1'b0;
    rd_last      = 1'b0;
    wr_step      = 1'b0;
    bus.mem_a    = 32'd0;
    bus.mem_wr   = 1'b0;
    bus.mem_dout = 8'd0;
    case (state)
      IDLE: begin
        if (st_av) begin
          grant_st  = 1'b1;
          state_nxt = WRITE;
        end else if (ld_av) begin
          grant_ld  = 1'b1;
          state_nxt = READ;
        end else if (if_av) begin
          grant_if  = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        // The last address stays on the bus while its byte is captured.
        bus.mem_a = act_addr + {29'd0, (cnt == act_n) ? act_n - 3'd1 : cnt};
        if (clear) begin
          state_nxt = IDLE;
        end else if (cnt == act_n) begin
          rd_last   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        bus.mem_a    = act_addr + {29'd0, cnt};
        bus.mem_dout = wr_word[7:0];
        bus.mem_wr   = rdy_in & ~stall;
        wr_step      = ~stall;
        if (!stall && cnt == act_n - 3'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request slots, active access, byte counter, capture and response pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      if_pend       <= 1'b0;
      ld_pend       <= 1'b0;
      st_pend       <= 1'b0;
      cnt           <= 3'd0;
      bus.if_valid  <= 1'b0;
      bus.if_inst   <= 32'd0;
      bus.mem_valid <= 1'b0;
      bus.mem_data  <= 32'd0;
      bus.st_done   <= 1'b0;
    end else if (rdy_in) begin
      bus.if_valid  <= 1'b0;
      bus.mem_valid <= 1'b0;
      bus.st_done   <= 1'b0;

      if (bus.st_request && !st_pend) begin
        st_addr_q <= bus.st_addr;
        st_type_q <= bus.st_type;
        st_data_q <= bus.st_data;
      end
      st_pend <= ~grant_st & (st_pend | bus.st_request);

      if (bus.lsb_request && !ld_pend) begin
        ld_addr_q <= bus.lsb_addr;
        ld_type_q <= bus.lsb_type;
        ld_sign_q <= bus.lsb_sign;
      end
      ld_pend <= ~clear & ~grant_ld & (ld_pend | bus.lsb_request);

      if (bus.if_request && !if_pend) if_addr_q <= bus.if_addr;
      if_pend <= ~clear & ~grant_if & (if_pend | bus.if_request);

      if (grant_st) begin
        act_addr  <= st_pend ? st_addr_q : bus.st_addr;
        act_data  <= st_pend ? st_data_q : bus.st_data;
        act_n     <= width_of(st_pend ? st_type_q : bus.st_type);
        act_sign  <= 1'b0;
        act_fetch <= 1'b0;
        cnt       <= 3'd0;
      end else if (grant_ld) begin
        act_addr  <= ld_pend ? ld_addr_q : bus.lsb_addr;
        act_n     <= width_of(ld_pend ? ld_type_q : bus.lsb_type);
        act_sign  <= ld_pend ? ld_sign_q : bus.lsb_sign;
        act_fetch <= 1'b0;
        cnt       <= 3'd0;
      end else if (grant_if) begin
        act_addr  <= if_pend ? if_addr_q : bus.if_addr;
        act_n     <= 3'd4;
        act_sign  <= 1'b0;
        act_fetch <= 1'b1;
        cnt       <= 3'd0;
      end else if (state == READ && !clear) begin
        cnt <= cnt + 3'd1;
        if (cnt != 3'd0) shreg <= rd_word;
        if (rd_last) begin
          if (act_fetch) begin
            bus.if_inst  <= rd_word;
            bus.if_valid <= 1'b1;
          end else begin
            bus.mem_data  <= extend(rd_word, act_n, act_sign);
            bus.mem_valid <= 1'b1;
          end
        end
      end else if (wr_step) begin
        cnt <= cnt + 3'd1;
        if (state_nxt == IDLE) bus.st_done <= 1'b1;
      end
    end
  end
endmodule
